// File: rtl/div_sequencer_if.sv
// Handshake bundle between the Execute stage and the iterative divider.
// The pipeline side uses the master modport; the divider uses slave.
interface div_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            ready_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  stall_o, busy_o, ready_o, result_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output stall_o, busy_o, ready_o, result_o
    );
endinterface

// File: rtl/div_sequencer.sv
// Iterative RV32M DIV/DIVU/REM/REMU controller with restoring-division datapath.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |a| < |b|.
module div_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    div_sequencer_if.slave div_io
);
    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] result_q;
    logic            op_rem_q;
    logic            signed_q;
    logic            sign_a_q;
    logic            sign_b_q;
    logic            ready_q;

    logic            is_signed;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero;
    logic            overflow;
    logic            shortcut;
    logic [XLEN-1:0] shortcut_res;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quo_d;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] final_res;
    logic            accept;

    // Operand decode and the single-cycle special cases seen in IDLE.
    always_comb begin
        is_signed    = ~div_io.op_i[0];
        sign_a       = is_signed & div_io.a_i[XLEN-1];
        sign_b       = is_signed & div_io.b_i[XLEN-1];
        a_abs        = sign_a ? ('0 - div_io.a_i) : div_io.a_i;
        b_abs        = sign_b ? ('0 - div_io.b_i) : div_io.b_i;
        div_zero     = (div_io.b_i == '0);
        overflow     = is_signed & (div_io.a_i == INT_MIN) & (div_io.b_i == '1);
        shortcut     = div_zero | overflow;
        shortcut_res = div_io.op_i[1] ? div_io.a_i : '0;
        if (div_zero) begin
            shortcut_res = div_io.op_i[1] ? div_io.a_i : '1;
        end else if (overflow) begin
            shortcut_res = div_io.op_i[1] ? '0 : INT_MIN;
        end
`ifdef DIV_EARLY_OUT_EN
        if (a_abs < b_abs) begin
            shortcut = 1'b1;
        end
`endif
        accept = (state_q == IDLE) & div_io.start_i & ~div_io.flush_i;
    end

    // One restoring step; the extra top bit of trial is the borrow.
    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        if (!trial[XLEN]) begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        quo_fix   = (signed_q & (sign_a_q ^ sign_b_q)) ? ('0 - quo_d) : quo_d;
        rem_fix   = (signed_q & sign_a_q) ? ('0 - rem_d) : rem_d;
        final_res = op_rem_q ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            op_rem_q <= 1'b0;
            signed_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (accept) begin
                        op_rem_q <= div_io.op_i[1];
                        signed_q <= is_signed;
                        sign_a_q <= sign_a;
                        sign_b_q <= sign_b;
                        dvs_q    <= b_abs;
                        if (shortcut) begin
                            result_q <= shortcut_res;
                            ready_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= a_abs;
                            cnt_q   <= CW'(XLEN - 1);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (div_io.flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        if (cnt_q == '0) begin
                            result_q <= final_res;
                            ready_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A flush landing on the DONE cycle suppresses the result pulse.
    assign div_io.ready_o  = ready_q & ~div_io.flush_i;
    assign div_io.result_o = result_q;
    assign div_io.busy_o   = (state_q != IDLE);
    assign div_io.stall_o  = rst_ni & (accept | (state_q == CALC));
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: per-cycle comparison against a transaction
// model using plain arithmetic, plus literal expectations from worked examples.
module tb_div_sequencer;
    localparam int unsigned XLEN = 32;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    div_sequencer_if #(.XLEN(XLEN)) bus ();
    div_sequencer #(.XLEN(XLEN)) dut (.clk_i(clk), .rst_ni(rst_ni), .div_io(bus));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit          pending = 1'b0;
    int          t_start = 0;
    int          t_done = 0;
    logic [31:0] exp_res = '0;
    logic [31:0] last_res = '0;

    logic        s_stall, s_busy, s_ready;
    logic [31:0] s_result;
    int          s_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == MIN32 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : MIN32;
            return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return op[1] ? a % b : a / b;
    endfunction

    function automatic int latency(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        longint ma, mb;
        ma = !op[0] ? longint'($signed(a)) : longint'(a);
        mb = !op[0] ? longint'($signed(b)) : longint'(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (b == 32'd0) return 1;
        if (!op[0] && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return XLEN + 1;
    endfunction

    function automatic bit busy_at(input int c);
        return pending && c > t_start && c <= t_done;
    endfunction

    task automatic compare_cycle();
        bit          b;
        logic [31:0] e_res;
        s_stall  = bus.stall_o;
        s_busy   = bus.busy_o;
        s_ready  = bus.ready_o;
        s_result = bus.result_o;
        s_cyc    = cyc;
        if (!rst_ni) begin
            check("rst_stall", {31'd0, s_stall}, 32'd0);
            check("rst_busy", {31'd0, s_busy}, 32'd0);
            check("rst_ready", {31'd0, s_ready}, 32'd0);
            check("rst_result", s_result, 32'd0);
        end else begin
            b     = busy_at(cyc);
            e_res = (pending && cyc == t_done) ? exp_res : last_res;
            check("busy", {31'd0, s_busy}, {31'd0, b});
            check("ready", {31'd0, s_ready},
                  {31'd0, pending && cyc == t_done && !bus.flush_i});
            check("stall", {31'd0, s_stall},
                  {31'd0, (bus.start_i && !bus.flush_i && !b) || (b && cyc < t_done)});
            check("result", s_result, e_res);
        end
    endtask

    task automatic model_update();
        if (!rst_ni) begin
            pending  = 1'b0;
            last_res = '0;
        end else if (pending && cyc == t_done) begin
            last_res = exp_res;
            pending  = 1'b0;
        end else if (busy_at(cyc)) begin
            if (bus.flush_i) pending = 1'b0;
        end else if (bus.start_i && !bus.flush_i) begin
            pending = 1'b1;
            t_start = cyc;
            t_done  = cyc + latency(bus.op_i, bus.a_i, bus.b_i);
            exp_res = ref_result(bus.op_i, bus.a_i, bus.b_i);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    // Holds start until the result pulse, as a stalled pipeline would.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lit, input int lat_lit);
        int t0;
        int nstall;
        bit found;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        t0     = cyc;
        nstall = 0;
        found  = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (s_stall) nstall++;
            if (s_ready) begin
                found = 1'b1;
                check({name, "_lat"}, 32'(s_cyc - t0), 32'(lat_lit));
                check({name, "_res"}, s_result, exp_lit);
                check({name, "_stallcnt"}, 32'(nstall), 32'(lat_lit));
            end
        end
        if (!found) check({name, "_timeout"}, 32'd0, 32'd1);
        bus.start_i = 1'b0;
        tick();
    endtask

    initial begin
        int t0;
        rst_ni      = 1'b0;
        bus.start_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.flush_i = 1'b0;
        repeat (3) tick();
        check("reset_busy", {31'd0, s_busy}, 32'd0);
        check("reset_result", s_result, 32'd0);
        rst_ni = 1'b1;
        tick();

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf", 2'b00, MIN32, 32'hFFFF_FFFF, MIN32, 1);
        run_op("rem_ovf", 2'b10, MIN32, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("div_max_u", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
`ifdef DIV_EARLY_OUT_EN
        run_op("divu_3_10", 2'b01, 32'd3, 32'd10, 32'd0, 1);
        run_op("rem_m3_7", 2'b10, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFD, 1);
`else
        run_op("divu_3_10", 2'b01, 32'd3, 32'd10, 32'd0, 33);
        run_op("rem_m3_7", 2'b10, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFD, 33);
`endif

        // Flush in the middle of CALC, then a fresh op two cycles later.
        bus.start_i = 1'b1;
        bus.op_i    = 2'b01;
        bus.a_i     = 32'd1000;
        bus.b_i     = 32'd3;
        t0 = cyc;
        repeat (10) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        tick();
        check("flush_idle_cyc", 32'(s_cyc - t0), 32'd11);
        check("flush_busy", {31'd0, s_busy}, 32'd0);
        check("flush_stall", {31'd0, s_stall}, 32'd0);
        check("flush_ready", {31'd0, s_ready}, 32'd0);
        run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33);

        // start and flush together in IDLE: nothing launches.
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        tick();
        check("sf_stall", {31'd0, s_stall}, 32'd0);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        tick();
        check("sf_busy", {31'd0, s_busy}, 32'd0);

        // Asynchronous reset during CALC.
        bus.start_i = 1'b1;
        bus.op_i    = 2'b01;
        bus.a_i     = 32'd1000;
        bus.b_i     = 32'd7;
        repeat (5) tick();
        rst_ni      = 1'b0;
        bus.start_i = 1'b0;
        tick();
        check("arst_busy", {31'd0, s_busy}, 32'd0);
        check("arst_stall", {31'd0, s_stall}, 32'd0);
        check("arst_result", s_result, 32'd0);
        tick();
        rst_ni = 1'b1;
        repeat (40) tick();
        check("arst_no_ready", {31'd0, s_ready}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Iterative RV32M divide controller for DIV/DIVU/REM/REMU in the Execute stage.
- Owns the FSM, iteration counter and restoring-division datapath.
- Generates a pipeline stall while a division is in flight and honours pipeline flushes.
- The pipeline controller ORs stall_o into its stall; its flush2exe/flush2mem outputs drive flush_i.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk_i  input  1  core clock
- rst_ni  input  1  asynchronous, active-low reset
- start_i  input  1  EXE has a valid divide op this cycle
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i
- a_i  input  XLEN  dividend (rs1); sampled with start_i
- b_i  input  XLEN  divisor (rs2); sampled with start_i
- flush_i  input  1  kill the in-flight operation
- stall_o  output  1  hold PC/FET/DEC/EXE registers
- busy_o  output  1  FSM not IDLE
- ready_o  output  1  result valid pulse, one cycle
- result_o  output  XLEN  quotient or remainder per the latched op; held until the next start

Behaviour:
- Reset (async, rst_ni=0): state=IDLE, counter=0, result_o=0, ready_o=0, busy_o=0. stall_o=0 while rst_ni=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 and flush_i=0: latch op, signs and |a|, |b| (two's-complement abs for DIV/REM; raw values for DIVU/REMU).
  - Divisor = 0: quotient=all ones, remainder=a_i; go to DONE.
  - DIV/REM with a_i=0x80000000 and b_i=0xFFFFFFFF: quotient=0x80000000, remainder=0; go to DONE.
  - Otherwise: counter=XLEN-1, go to CALC.
- CALC, each cycle: shift {rem,quo} left 1, trial-subtract |b|. If non-negative, keep the difference and set quo[0]=1. When counter=0, go to DONE; otherwise decrement.
- Sign fix on entering DONE:
  - Quotient is negated if sign_a^sign_b (signed ops).
  - Remainder is negated if sign_a (signed ops).
- DONE: ready_o=1, result_o valid, stall_o=0 (the pipeline advances and captures the result). Go to IDLE next cycle.
- stall_o = (IDLE & start_i & ~flush_i) | CALC. This term is combinational from start_i.
- busy_o = state != IDLE.
- Latency, start_i asserted at cycle T:
  - Normal path: CALC for T+1..T+XLEN, DONE at T+XLEN+1 (T+33).
  - Special cases: DONE at T+1.
- flush_i:
  - In CALC or DONE: state goes to IDLE next cycle, ready_o forced 0 that cycle, result_o unchanged.
  - With start_i in IDLE: flush wins, nothing latched, stall_o=0.
- start_i outside IDLE is ignored; the pipeline is stalled, so the same instruction re-presents start_i until DONE. In DONE, start_i is ignored.
- Async reset mid-CALC: immediate return to IDLE; no ready_o.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, a non-special op with |a| < |b| goes straight to DONE with quotient=0 and remainder=a_i (original signed value). Latency is T+1.
- Undefined: these ops take the full XLEN-iteration path. Results are identical either way; only latency differs.

Test Plan:
- DIVU a=100 b=7 at T -> stall_o=1 T..T+32; ready_o=1 at T+33, result_o=14. Repeat with REMU -> 2.
- DIV a=0xFFFFFFF9 (-7) b=2 -> result_o=0xFFFFFFFD. REM same operands -> 0xFFFFFFFF.
- DIVU 5/0 -> ready_o at T+1, result_o=0xFFFFFFFF. REM 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1. REM same -> 0.
- DIVU 1000/3 started, flush_i at T+10 -> IDLE at T+11, no ready_o, stall_o=0. New DIVU 9/3 at T+12 -> result 3 at T+45. Also start_i&flush_i together -> no busy_o.
- DIVU 3/10 -> result 0. Macro defined: ready_o at T+1. Undefined: ready_o at T+33. Also assert rst_ni=0 at T+5 of a DIVU -> all outputs 0 immediately, no ready_o.
